// File: rtl/mi_arb_pkg.sv
// mi_arb_pkg: shared definitions for the MI32 round-robin arbiter.
//   - arb_state_e : arbiter FSM states (idle / grant)
//   - MiDataW, MiAddrW, MiBeW : MI32 data, address and byte-enable widths
//   - idx_width() : bits needed to index n items (minimum 1)
package mi_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned MiDataW = 32;
    localparam int unsigned MiAddrW = 32;
    localparam int unsigned MiBeW   = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mi_arb_fifo.sv
// mi_arb_fifo: synchronous FIFO holding the master index of each outstanding read.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_push, i_data  write an entry (ignored when full without a simultaneous pop)
//   i_pop           drop the head entry (ignored when empty)
//   o_data          head entry, valid when o_empty is low
//   o_full, o_empty occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module mi_arb_fifo
    import mi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = idx_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push would need.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + (PW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/mi_rr_arbiter.sv
// mi_rr_arbiter: round-robin arbiter letting MASTERS MI32 masters share one slave.
// Ports:
//   CLK, RESET                   clock, synchronous active-low reset
//   S_DWR/S_ADDR/S_BE/S_RD/S_WR  per-master request buses (packed, master 0 in LSBs)
//   S_ARDY, S_DRD, S_DRDY        per-master accept, read data and read-data valid
//   M_DWR/M_ADDR/M_BE/M_RD/M_WR  request forwarded from the granted master
//   M_ARDY, M_DRDY, M_DRD        slave accept, read-data valid and read data
//   ERR                          sticky protocol error (withdrawn request, unexpected data)
//   GRANT_CNT                    per-master 16-bit accepted-transaction counters, present
//                                only when MI_ARB_GRANT_CNT_EN is defined
// Read data returns in order; a FIFO of master indices routes each response.
module mi_rr_arbiter
    import mi_arb_pkg::*;
#(
    parameter int unsigned MASTERS = 4,
    parameter int unsigned MAX_RD  = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [MASTERS*MiDataW-1:0] S_DWR,
    input  logic [MASTERS*MiAddrW-1:0] S_ADDR,
    input  logic [MASTERS*MiBeW-1:0]   S_BE,
    input  logic [MASTERS-1:0]         S_RD,
    input  logic [MASTERS-1:0]         S_WR,
    output logic [MASTERS-1:0]         S_ARDY,
    output logic [MASTERS*MiDataW-1:0] S_DRD,
    output logic [MASTERS-1:0]         S_DRDY,
    output logic [MiDataW-1:0]         M_DWR,
    output logic [MiAddrW-1:0]         M_ADDR,
    output logic [MiBeW-1:0]           M_BE,
    output logic                       M_RD,
    output logic                       M_WR,
    input  logic                       M_ARDY,
    input  logic                       M_DRDY,
    input  logic [MiDataW-1:0]         M_DRD,
    output logic                       ERR
`ifdef MI_ARB_GRANT_CNT_EN
    ,
    output logic [MASTERS*16-1:0]      GRANT_CNT
`endif
);

    localparam int unsigned IW = idx_width(MASTERS);

    arb_state_e         r_state;
    arb_state_e         w_state_next;
    logic [IW-1:0]      r_win;
    logic [IW-1:0]      w_win_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_ptr_next;
    logic [IW-1:0]      w_sel;
    logic [IW-1:0]      w_head;
    logic [MASTERS-1:0] w_elig;
    logic               w_any_elig;
    logic               r_err;
    logic               w_err_next;
    logic               r_out_en;
    logic               w_out_en;
    logic               w_g_rd;
    logic               w_g_wr;
    logic               w_accept;
    logic               w_push;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // Outputs stay quiet while in reset and for the first cycle after release.
    assign w_out_en = RESET && r_out_en;
    assign w_g_rd   = S_RD[r_win];
    assign w_g_wr   = S_WR[r_win];
    assign w_elig   = S_WR | (S_RD & {MASTERS{~w_fifo_full}});

    mi_arb_fifo #(
        .DEPTH (MAX_RD),
        .WIDTH (IW)
    ) u_rd_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_data  (r_win),
        .i_pop   (M_DRDY),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // First eligible master at or after the round-robin pointer.
    always_comb begin : p_rr_pick
        int unsigned j;
        j          = 0;
        w_any_elig = 1'b0;
        w_sel      = '0;
        for (int unsigned k = 0; k < MASTERS; k++) begin
            j = (32'(r_ptr) + k) % MASTERS;
            if (!w_any_elig && w_elig[j]) begin
                w_any_elig = 1'b1;
                w_sel      = IW'(j);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_win_next   = r_win;
        w_ptr_next   = r_ptr;
        w_err_next   = r_err;
        w_accept     = 1'b0;
        w_push       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_elig) begin
                    w_state_next = StGrant;
                    w_win_next   = w_sel;
                end
            end
            StGrant: begin
                if (M_ARDY && (w_g_rd || w_g_wr)) begin
                    w_accept     = 1'b1;
                    w_push       = w_g_rd;
                    w_ptr_next   = (r_win == IW'(MASTERS - 1)) ? '0 : r_win + IW'(1);
                    w_state_next = StIdle;
                end else if (!w_g_rd && !w_g_wr) begin
                    // Master dropped its request while granted.
                    w_err_next   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (M_DRDY && w_fifo_empty) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= StIdle;
            r_win    <= '0;
            r_ptr    <= '0;
            r_err    <= 1'b0;
            r_out_en <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_win    <= w_win_next;
            r_ptr    <= w_ptr_next;
            r_err    <= w_err_next;
            r_out_en <= 1'b1;
        end
    end

    always_comb begin
        M_DWR  = '0;
        M_ADDR = '0;
        M_BE   = '0;
        M_RD   = 1'b0;
        M_WR   = 1'b0;
        S_ARDY = '0;
        S_DRDY = '0;
        S_DRD  = '0;
        ERR    = 1'b0;
        if (w_out_en) begin
            if (r_state == StGrant) begin
                M_DWR         = S_DWR[32'(r_win)*MiDataW +: MiDataW];
                M_ADDR        = S_ADDR[32'(r_win)*MiAddrW +: MiAddrW];
                M_BE          = S_BE[32'(r_win)*MiBeW +: MiBeW];
                M_RD          = w_g_rd;
                M_WR          = w_g_wr;
                S_ARDY[r_win] = M_ARDY;
            end
            if (M_DRDY && !w_fifo_empty) begin
                S_DRDY[w_head]                          = 1'b1;
                S_DRD[32'(w_head)*MiDataW +: MiDataW] = M_DRD;
            end
            ERR = r_err;
        end
    end

`ifdef MI_ARB_GRANT_CNT_EN
    logic [15:0] r_gcnt [MASTERS];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < MASTERS; i++) begin
                r_gcnt[i] <= '0;
            end
        end else if (w_accept) begin
            r_gcnt[r_win] <= r_gcnt[r_win] + 16'd1;
        end
    end

    always_comb begin
        GRANT_CNT = '0;
        if (w_out_en) begin
            for (int unsigned i = 0; i < MASTERS; i++) begin
                GRANT_CNT[i*16 +: 16] = r_gcnt[i];
            end
        end
    end
`endif

endmodule
